// File: rtl/gat_pkg.sv
// Shared GAT definitions: width derivations for the num_node store (used by the
// writer and this reader) and the read-pass state encoding.
package gat_pkg;

  localparam int MAX_NODES_DEFAULT     = 168;
  localparam int NUM_SUBGRAPHS_DEFAULT = 2708;

  // Width of a per-subgraph node count.
  function automatic int num_node_width(input int max_nodes);
    return (max_nodes > 1) ? $clog2(max_nodes) : 1;
  endfunction

  // Width of a BRAM address / subgraph index.
  function automatic int num_node_addr_w(input int num_subgraphs);
    return (num_subgraphs > 1) ? $clog2(num_subgraphs) : 1;
  endfunction

  // Counters that must be able to hold NUM_SUBGRAPHS itself.
  function automatic int num_node_cnt_w(input int num_subgraphs);
    return $clog2(num_subgraphs + 1);
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rd_state_e;

endpackage

// File: rtl/num_node_fifo.sv
// Synchronous FIFO whose head entry sits in an output register; count_o
// includes that head entry. Push and pop may coincide at any occupancy.
module num_node_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             vld_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [CNT_W-1:0] count_q, remaining;
  logic             pop;

  always_comb begin
    pop        = pop_i & vld_o;
    rd_ptr_nxt = rd_ptr_q + PTR_W'(pop);
    remaining  = count_q - CNT_W'(pop);
  end

  // NOTE: the storage array has no reset; count_q alone says which slots are
  // meaningful, which keeps the array mappable to distributed RAM.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_o   <= '0;
      vld_o    <= 1'b0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      rd_ptr_q <= rd_ptr_nxt;
      count_q  <= remaining + CNT_W'(push_i);
      // Reload the head: an older stored entry wins, else bypass the push.
      if (remaining != '0) begin
        dout_o <= mem_q[rd_ptr_nxt];
        vld_o  <= 1'b1;
      end else if (push_i) begin
        dout_o <= din_i;
        vld_o  <= 1'b1;
      end else begin
        vld_o  <= 1'b0;
      end
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/num_node_reader.sv
// Streams per-subgraph node counts out of the num_node BRAM in index order,
// never reading ahead of the writer, with credit-limited prefetch.
module num_node_reader
  import gat_pkg::*;
#(
  parameter int  MAX_NODES       = MAX_NODES_DEFAULT,
  parameter int  NUM_SUBGRAPHS   = NUM_SUBGRAPHS_DEFAULT,
  parameter int  BRAM_RD_LATENCY = 2,
  parameter int  FIFO_DEPTH      = 4,
  localparam int NUM_NODE_WIDTH  = num_node_width(MAX_NODES),
  localparam int NUM_NODE_ADDR_W = num_node_addr_w(NUM_SUBGRAPHS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic                       wr_ena_i,
  output logic                       num_node_bram_enb,
  output logic [NUM_NODE_ADDR_W-1:0] num_node_bram_addrb,
  input  logic [NUM_NODE_WIDTH-1:0]  num_node_bram_doutb,
  output logic [NUM_NODE_WIDTH-1:0]  num_node_o,
  output logic [NUM_NODE_ADDR_W-1:0] num_node_idx_o,
  output logic                       num_node_last_o,
  output logic                       num_node_vld_o,
  input  logic                       num_node_rdy_i,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int CNT_W  = num_node_cnt_w(NUM_SUBGRAPHS);
  localparam int FIFO_W = NUM_NODE_ADDR_W + NUM_NODE_WIDTH;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int LAT    = BRAM_RD_LATENCY;

  localparam logic [CNT_W-1:0]           N_ENTRIES = CNT_W'(NUM_SUBGRAPHS);
  localparam logic [NUM_NODE_ADDR_W-1:0] LAST_IDX  = NUM_NODE_ADDR_W'(NUM_SUBGRAPHS - 1);

  rd_state_e                  state_q, state_d;
  logic [CNT_W-1:0]           wr_cnt_q, rd_addr_q;
  logic [LAT-1:0]             pipe_vld_q;
  logic [NUM_NODE_ADDR_W-1:0] pipe_idx_q [LAT];
  logic [FCNT_W-1:0]          fifo_count;
  logic [FIFO_W-1:0]          fifo_dout;
  logic                       fifo_vld;
  logic                       accept;
  logic                       issue;
  int                         occupancy;

  assign accept = fifo_vld & num_node_rdy_i;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (accept && num_node_last_o) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: flops use non-blocking assignments so every register in the design
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Credit rule: entries in flight plus entries queued never exceed the FIFO,
  // so the tail of the read pipe can always push.
  always_comb begin
    occupancy = int'(fifo_count) + $countones(pipe_vld_q);
    issue     = (state_q == RUN)
             && (rd_addr_q < N_ENTRIES)
             && (rd_addr_q < wr_cnt_q)
             && (occupancy < FIFO_DEPTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q  <= '0;
      rd_addr_q <= '0;
    end else if (state_q == DONE) begin
      wr_cnt_q  <= '0;
      rd_addr_q <= '0;
    end else begin
      if (wr_ena_i && (wr_cnt_q != N_ENTRIES)) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      if (issue) rd_addr_q <= rd_addr_q + CNT_W'(1);
    end
  end

  // In-flight pipe: its tail lines up with the cycle doutb becomes valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld_q <= '0;
    end else begin
      pipe_vld_q[0] <= issue;
      for (int i = 1; i < LAT; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_idx_q[0] <= rd_addr_q[NUM_NODE_ADDR_W-1:0];
    for (int i = 1; i < LAT; i++) pipe_idx_q[i] <= pipe_idx_q[i-1];
  end

  num_node_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (pipe_vld_q[LAT-1]),
    .din_i   ({pipe_idx_q[LAT-1], num_node_bram_doutb}),
    .pop_i   (accept),
    .dout_o  (fifo_dout),
    .vld_o   (fifo_vld),
    .count_o (fifo_count)
  );

  assign num_node_bram_enb   = issue;
  assign num_node_bram_addrb = issue ? rd_addr_q[NUM_NODE_ADDR_W-1:0] : '0;

  assign {num_node_idx_o, num_node_o} = fifo_dout;
  assign num_node_vld_o  = fifo_vld;
  assign num_node_last_o = fifo_vld && (num_node_idx_o == LAST_IDX);

  assign busy_o = (state_q == RUN);
  assign done_o = (state_q == DONE);

endmodule
